// File: rtl/debug_bus_master_pkg.sv
// Shared constants and state encoding for the UART-driven debug bus master.
package debug_bus_master_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RESP_ACK  = 8'h4B;
  localparam logic [7:0] RESP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_GRANT,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/debug_bus_master_if.sv
// Byte stream and processor data-bus signals of the debug bus master.
// The master modport is the block's view, slave is the surrounding system.
interface debug_bus_master_if;

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_hold;
  logic        bus_grant;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        frame_error;

  modport master (
    input  rx_byte, rx_valid, tx_ready, bus_grant, bus_read_data,
    output rx_ready, tx_byte, tx_valid, bus_hold, bus_address,
           bus_read, bus_write, bus_write_data, frame_error
  );

  modport slave (
    output rx_byte, rx_valid, tx_ready, bus_grant, bus_read_data,
    input  rx_ready, tx_byte, tx_valid, bus_hold, bus_address,
           bus_read, bus_write, bus_write_data, frame_error
  );

endinterface

// File: rtl/debug_bus_master_frame_timeout_counter.sv
// Counts idle cycles inside a frame; expire fires once TIMEOUT_CYCLES
// cycles have passed since the last accepted byte.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expire = enable && !reload && (count == CW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter, cleared outside frames, on each byte and on expiry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable || reload || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/debug_bus_master.sv
// Debug bus master: decodes read/write frames from a UART byte stream,
// takes ownership of the processor data bus and returns the result.
module debug_bus_master
  import debug_bus_master_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                 clock,
  input logic                 reset,
  debug_bus_master_if.master  bus
);

  state_t      state, state_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic [1:0]  wait_cnt, wait_cnt_n;
  logic        is_write, is_write_n;
  logic [31:0] address, address_n;
  logic [31:0] write_data, write_data_n;
  logic [31:0] resp_data, resp_data_n;
  logic [7:0]  tx_byte, tx_byte_n;
  logic        tx_valid, tx_valid_n;
  logic        hold, hold_n;
  logic        read_strobe, read_strobe_n;
  logic        write_strobe, write_strobe_n;
  logic        error, error_n;
  logic        rx_ready, rx_fire, tx_fire, expire, in_frame;

  assign in_frame = (state == ST_ADDR) || (state == ST_DATA);
  assign rx_ready = ((state == ST_IDLE) || in_frame) && !tx_valid;
  assign rx_fire  = bus.rx_valid && rx_ready;
  assign tx_fire  = tx_valid && bus.tx_ready;

  assign bus.rx_ready       = rx_ready;
  assign bus.tx_byte        = tx_byte;
  assign bus.tx_valid       = tx_valid;
  assign bus.bus_hold       = hold;
  assign bus.bus_address    = address;
  assign bus.bus_read       = read_strobe;
  assign bus.bus_write      = write_strobe;
  assign bus.bus_write_data = write_data;
  assign bus.frame_error    = error;

  frame_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .enable (in_frame),
    .reload (rx_fire),
    .expire (expire)
  );

  // State and datapath registers; reset abandons any frame or access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
      is_write     <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      resp_data    <= '0;
      tx_byte      <= '0;
      tx_valid     <= 1'b0;
      hold         <= 1'b0;
      read_strobe  <= 1'b0;
      write_strobe <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      byte_cnt     <= byte_cnt_n;
      wait_cnt     <= wait_cnt_n;
      is_write     <= is_write_n;
      address      <= address_n;
      write_data   <= write_data_n;
      resp_data    <= resp_data_n;
      tx_byte      <= tx_byte_n;
      tx_valid     <= tx_valid_n;
      hold         <= hold_n;
      read_strobe  <= read_strobe_n;
      write_strobe <= write_strobe_n;
      error        <= error_n;
    end
  end

  // Frame decode, bus sequencing and response generation.
  always_comb begin
    state_n        = state;
    byte_cnt_n     = byte_cnt;
    wait_cnt_n     = wait_cnt;
    is_write_n     = is_write;
    address_n      = address;
    write_data_n   = write_data;
    resp_data_n    = resp_data;
    tx_byte_n      = tx_byte;
    tx_valid_n     = tx_valid;
    read_strobe_n  = 1'b0;
    write_strobe_n = 1'b0;
    error_n        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tx_fire) tx_valid_n = 1'b0;
        if (rx_fire) begin
          byte_cnt_n = '0;
          if (bus.rx_byte == CMD_READ) begin
            is_write_n = 1'b0;
            state_n    = ST_ADDR;
          end else if (bus.rx_byte == CMD_WRITE) begin
            is_write_n = 1'b1;
            state_n    = ST_ADDR;
          end else begin
            tx_byte_n  = RESP_ERR;
            tx_valid_n = 1'b1;
            error_n    = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (expire) begin
          state_n    = ST_IDLE;
          byte_cnt_n = '0;
          error_n    = 1'b1;
        end else if (rx_fire) begin
          address_n  = {address[23:0], bus.rx_byte};
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_n = is_write ? ST_DATA : ST_GRANT;
        end
      end
      ST_DATA: begin
        if (expire) begin
          state_n    = ST_IDLE;
          byte_cnt_n = '0;
          error_n    = 1'b1;
        end else if (rx_fire) begin
          write_data_n = {write_data[23:0], bus.rx_byte};
          byte_cnt_n   = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bus.bus_grant) begin
          state_n        = ST_ACCESS;
          read_strobe_n  = !is_write;
          write_strobe_n = is_write;
        end
      end
      ST_ACCESS: begin
        if (is_write) begin
          state_n    = ST_RESP;
          tx_byte_n  = RESP_ACK;
          tx_valid_n = 1'b1;
        end else begin
          state_n    = ST_WAIT;
          wait_cnt_n = '0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 2'(READ_LATENCY - 1)) begin
          resp_data_n = bus.bus_read_data;
          tx_byte_n   = bus.bus_read_data[31:24];
          tx_valid_n  = 1'b1;
          byte_cnt_n  = '0;
          state_n     = ST_RESP;
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end
      ST_RESP: begin
        if (tx_fire) begin
          if (is_write || byte_cnt == 2'd3) begin
            tx_valid_n = 1'b0;
            byte_cnt_n = '0;
            state_n    = ST_IDLE;
          end else begin
            byte_cnt_n  = byte_cnt + 2'd1;
            resp_data_n = {resp_data[23:0], 8'h00};
            tx_byte_n   = resp_data[23:16];
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    hold_n = (state_n == ST_GRANT) || (state_n == ST_ACCESS) || (state_n == ST_WAIT);
  end

endmodule

// File: tb/tb_debug_bus_master.sv
// Directed testbench for debug_bus_master with a negedge bus/tx monitor.
module tb_debug_bus_master;

  logic clock;
  logic reset;

  int checks = 0;
  int fails  = 0;

  int          read_count  = 0;
  int          write_count = 0;
  int          error_count = 0;
  logic [31:0] read_addr   = '0;
  logic [31:0] write_addr  = '0;
  logic [31:0] write_value = '0;
  logic [7:0]  tx_log[$];

  debug_bus_master_if ifc ();

  debug_bus_master #(.READ_LATENCY(2), .TIMEOUT_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.master)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Records bus strobes, error pulses and tx handshakes between edges.
  always @(negedge clock) begin
    if (ifc.bus_read) begin
      read_count++;
      read_addr = ifc.bus_address;
    end
    if (ifc.bus_write) begin
      write_count++;
      write_addr  = ifc.bus_address;
      write_value = ifc.bus_write_data;
    end
    if (ifc.frame_error) error_count++;
    if (ifc.tx_valid && ifc.tx_ready) tx_log.push_back(ifc.tx_byte);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tx_at(input int i);
    if (i < tx_log.size()) return {24'h0, tx_log[i]};
    return 'x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int   budget = 0;
    logic done   = 1'b0;
    ifc.rx_byte  = b;
    ifc.rx_valid = 1'b1;
    while (!done && budget < 200) begin
      done = ifc.rx_ready;
      @(posedge clock); #1;
      budget++;
    end
    ifc.rx_valid = 1'b0;
    check("rx_accept", {31'h0, done}, 32'h1);
  endtask

  task automatic send_read(input logic [31:0] addr);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [31:0] data);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n);
    int budget = 0;
    while (tx_log.size() < n && budget < 200) begin
      @(posedge clock); #1;
      budget++;
    end
    check("tx_count", tx_log.size(), n);
  endtask

  // Directed sequence of scenarios.
  initial begin
    int base_rd, base_wr, base_err, hold_drops;

    reset              = 1'b0;
    ifc.rx_byte        = '0;
    ifc.rx_valid       = 1'b0;
    ifc.tx_ready       = 1'b1;
    ifc.bus_grant      = 1'b1;
    ifc.bus_read_data  = 32'hDEADBEEF;
    repeat (3) @(posedge clock);
    #1;

    check("rst_rx_ready", ifc.rx_ready, 1);
    check("rst_tx_valid", ifc.tx_valid, 0);
    check("rst_tx_byte", ifc.tx_byte, 0);
    check("rst_bus_hold", ifc.bus_hold, 0);
    check("rst_bus_read", ifc.bus_read, 0);
    check("rst_bus_write", ifc.bus_write, 0);
    check("rst_bus_address", ifc.bus_address, 0);
    check("rst_bus_write_data", ifc.bus_write_data, 0);
    check("rst_frame_error", ifc.frame_error, 0);

    reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] read frame at 0x00000104");
    tx_log.delete();
    send_read(32'h0000_0104);
    wait_tx(4);
    check("rd_count", read_count, 1);
    check("rd_addr", read_addr, 32'h0000_0104);
    check("rd_no_write", write_count, 0);
    check("rd_tx0", tx_at(0), 32'hDE);
    check("rd_tx1", tx_at(1), 32'hAD);
    check("rd_tx2", tx_at(2), 32'hBE);
    check("rd_tx3", tx_at(3), 32'hEF);
    @(posedge clock); #1;
    check("rd_hold_released", ifc.bus_hold, 0);

    $display("[TB] write frame at 0x00000010");
    tx_log.delete();
    send_write(32'h0000_0010, 32'h1234_5678);
    wait_tx(1);
    check("wr_count", write_count, 1);
    check("wr_addr", write_addr, 32'h0000_0010);
    check("wr_data", write_value, 32'h1234_5678);
    check("wr_no_read", read_count, 1);
    check("wr_tx0", tx_at(0), 32'h4B);

    $display("[TB] unknown command 0x41");
    tx_log.delete();
    base_err = error_count;
    send_byte(8'h41);
    wait_tx(1);
    check("unk_tx0", tx_at(0), 32'h3F);
    check("unk_error_pulse", error_count, base_err + 1);
    tx_log.delete();
    ifc.bus_read_data = 32'h0102_0304;
    send_read(32'h0000_0008);
    wait_tx(4);
    check("unk_next_rd_count", read_count, 2);
    check("unk_next_rd_addr", read_addr, 32'h0000_0008);
    check("unk_next_tx0", tx_at(0), 32'h01);
    check("unk_next_tx3", tx_at(3), 32'h04);

    $display("[TB] timeout after partial read frame");
    tx_log.delete();
    base_err = error_count;
    base_rd  = read_count;
    base_wr  = write_count;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (30) @(posedge clock);
    #1;
    check("to_error_pulse", error_count, base_err + 1);
    check("to_no_tx", tx_log.size(), 0);
    check("to_no_read", read_count, base_rd);
    check("to_no_write", write_count, base_wr);
    check("to_idle_ready", ifc.rx_ready, 1);
    check("to_no_hold", ifc.bus_hold, 0);

    $display("[TB] grant withheld for 50 cycles");
    tx_log.delete();
    ifc.bus_grant = 1'b0;
    base_rd = read_count;
    send_read(32'h0000_0020);
    hold_drops = 0;
    for (int i = 0; i < 50; i++) begin
      if (!ifc.bus_hold) hold_drops++;
      @(posedge clock); #1;
    end
    check("gr_hold_throughout", hold_drops, 0);
    check("gr_no_strobe", read_count, base_rd);
    check("gr_no_tx", tx_log.size(), 0);
    ifc.bus_grant = 1'b1;
    wait_tx(4);
    check("gr_rd_count", read_count, base_rd + 1);
    check("gr_rd_addr", read_addr, 32'h0000_0020);
    check("gr_tx0", tx_at(0), 32'h01);

    $display("[TB] reset during WAIT with tx_ready low");
    tx_log.delete();
    ifc.tx_ready = 1'b0;
    send_read(32'h0000_0030);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rw_hold_in_wait", ifc.bus_hold, 1);
    reset = 1'b0;
    #1;
    check("rw_rx_ready", ifc.rx_ready, 1);
    check("rw_tx_valid", ifc.tx_valid, 0);
    check("rw_tx_byte", ifc.tx_byte, 0);
    check("rw_bus_hold", ifc.bus_hold, 0);
    check("rw_bus_read", ifc.bus_read, 0);
    check("rw_bus_address", ifc.bus_address, 0);
    check("rw_frame_error", ifc.frame_error, 0);
    base_rd  = read_count;
    base_wr  = write_count;
    base_err = error_count;
    repeat (2) @(posedge clock);
    #1;
    reset        = 1'b1;
    ifc.tx_ready = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("rw_no_read_after", read_count, base_rd);
    check("rw_no_write_after", write_count, base_wr);
    check("rw_no_error_after", error_count, base_err);
    check("rw_no_tx_after", tx_log.size(), 0);
    check("rw_idle_ready", ifc.rx_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/debug_bus_master.md
DEBUG_BUS_MASTER -- requirements
Module: debug_bus_master

Interface
REQ-001 Parameter READ_LATENCY, default 1: cycles from bus_read pulse to valid bus_read_data (1..3).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between bytes of one frame.
REQ-003 Single clock, reset asynchronous and active-low.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 rx_byte  in  8  received byte from UART core.
REQ-007 rx_valid  in  1  rx_byte valid this cycle.
REQ-008 rx_ready  out  1  block accepts rx_byte; transfer when rx_valid and rx_ready are both high.
REQ-009 tx_byte  out  8  response byte to UART core.
REQ-010 tx_valid  out  1  tx_byte valid; held with stable tx_byte until tx_ready.
REQ-011 tx_ready  in  1  UART core accepts tx_byte.
REQ-012 bus_hold  out  1  request for processor data-bus ownership.
REQ-013 bus_grant  in  1  ownership granted; processor stalled.
REQ-014 bus_address  out  32  word address driven to data bus.
REQ-015 bus_read  out  1  single-cycle read strobe.
REQ-016 bus_write  out  1  single-cycle write strobe.
REQ-017 bus_write_data  out  32  write data.
REQ-018 bus_read_data  in  32  read data from bus mux.
REQ-019 frame_error  out  1  one-cycle pulse on timeout or unknown command.

Function
REQ-020 Frames: 0x52 + 4 address bytes = read; 0x57 + 4 address bytes + 4 data bytes = write; all multi-byte fields MSB first.
REQ-021 States IDLE, ADDR, DATA, GRANT, ACCESS, WAIT, RESP; IDLE -> ADDR on 0x52/0x57.
REQ-022 Any other command byte in IDLE: send 0x3F, pulse frame_error, return to IDLE.
REQ-023 ADDR -> DATA after 4th address byte of write; ADDR -> GRANT after 4th byte of read; DATA -> GRANT after 4th data byte.
REQ-024 rx_ready high only in IDLE, ADDR, DATA and never while tx_valid is high.
REQ-025 Byte counter 2 bits, wraps 3 -> 0 at each field end.
REQ-026 Timeout counter reloads on every accepted byte in ADDR/DATA; on reaching TIMEOUT_CYCLES: discard frame, pulse frame_error, go IDLE, no response byte.
REQ-027 bus_hold asserted from GRANT entry until RESP entry, cleared on the RESP entry cycle.
REQ-028 GRANT waits indefinitely for bus_grant; no timeout in GRANT.
REQ-029 ACCESS: exactly one cycle of bus_read or bus_write, bus_address/bus_write_data stable from GRANT through WAIT.
REQ-030 Read: WAIT lasts READ_LATENCY cycles, bus_read_data captured on the last one; write: WAIT skipped.
REQ-031 RESP read: 4 data bytes MSB first; RESP write: single byte 0x4B; IDLE after final tx handshake.
REQ-032 bus_grant deassertion during ACCESS/WAIT is ignored; access completes.
REQ-033 rx_valid while rx_ready low is not this block's loss; UART core holds or drops per its own rules.

Reset
REQ-034 On reset low: state IDLE, counters 0, rx_ready 1, tx_valid 0, tx_byte 0x00, bus_hold 0, bus_read 0, bus_write 0, bus_address 0, bus_write_data 0, frame_error 0.
REQ-035 Reset mid-frame or mid-access abandons it immediately; no partial strobe after release.

Structure
REQ-036 Shared package holds command/response byte constants (0x52, 0x57, 0x4B, 0x3F) and the state encoding.
REQ-037 One sub-module natural: frame_timeout_counter (reload, expire pulse).

Verification
REQ-038 Bytes 52 00 00 01 04, bus_read_data 0xDEADBEEF, grant immediate -> one bus_read at 0x00000104, tx DE AD BE EF.
REQ-039 Bytes 57 00 00 00 10 12 34 56 78 -> one bus_write at 0x00000010 data 0x12345678, tx 4B.
REQ-040 Byte 0x41 in IDLE -> tx 3F, frame_error pulse, next valid frame processed normally.
REQ-041 52 00 00 then silence > TIMEOUT_CYCLES (set 16) -> frame_error pulse, no tx, no bus strobe.
REQ-042 bus_grant held low 50 cycles after read frame -> bus_hold high throughout, no strobe until grant.
REQ-043 Reset asserted during WAIT with tx_ready low -> all outputs at reset values, no strobe and no tx after release.
